// File: rtl/beam_pkg.sv
// Shared constants, FSM state type and accumulator sizing for the beam sum accumulator.
package beam_pkg;

    localparam int NUM_MICS = 16;
    localparam int PCM_W    = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } beam_state_e;

    // Width that holds the sum of num_ch signed pcm_w-bit samples without overflow
    function automatic int acc_width(input int num_ch, input int pcm_w);
        return pcm_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/beam_sum_accumulator_if.sv
// Frame input, beam output handshake and status signals of the beam sum accumulator.
interface beam_sum_accumulator_if
    import beam_pkg::*;
#(
    parameter int NUM_CH = NUM_MICS,
    parameter int IN_W   = PCM_W
);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    logic [NUM_CH*IN_W-1:0] pcm_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_CH-1:0]      ch_enable;
    logic signed [IN_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [CNT_W-1:0]       active_count;
    logic                   busy;
    logic                   overrun;
    logic                   overrun_clr;

    modport master (
        output pcm_in, in_valid, ch_enable, out_ready, overrun_clr,
        input  in_ready, out_data, out_valid, active_count, busy, overrun
    );

    modport slave (
        input  pcm_in, in_valid, ch_enable, out_ready, overrun_clr,
        output in_ready, out_data, out_valid, active_count, busy, overrun
    );

endinterface

// File: rtl/beam_shift_sat.sv
// Arithmetic right shift (floor) of the wide channel sum followed by clamping to the output range.
module beam_shift_sat #(
    parameter int ACC_W = 23,
    parameter int OUT_W = 19,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] sat
);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted_s;

    // Shift then clamp to the signed OUT_W range
    always_comb begin
        shifted_s = acc >>> SHIFT;
        if (shifted_s > MAX_V) begin
            sat = MAX_V[OUT_W-1:0];
        end else if (shifted_s < MIN_V) begin
            sat = MIN_V[OUT_W-1:0];
        end else begin
            sat = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/beam_sum_accumulator.sv
// Serially sums the enabled channels of one snapshotted frame, then shifts/saturates into one beam sample.
module beam_sum_accumulator
    import beam_pkg::*;
#(
    parameter int NUM_CH = NUM_MICS,
    parameter int IN_W   = PCM_W,
    parameter int SHIFT  = 4
) (
    input logic                  clk,
    input logic                  rst,
    beam_sum_accumulator_if.slave bus
);
    localparam int ACC_W = acc_width(NUM_CH, IN_W);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    beam_state_e             state_r;
    logic signed [IN_W-1:0]  snap_r [NUM_CH];
    logic [NUM_CH-1:0]       mask_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        idx_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    overrun_r;
    logic signed [IN_W-1:0]  out_data_r;
    logic [CNT_W-1:0]        active_count_r;
    logic [IDX_W-1:0]        ch_sel_s;
    logic signed [ACC_W-1:0] addend_s;
    logic signed [IN_W-1:0]  sat_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] m);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            n = n + CNT_W'(m[k]);
        end
        return n;
    endfunction

    // Sign-extended contribution of the channel selected by the index counter
    always_comb begin
        ch_sel_s = idx_r[IDX_W-1:0];
        if (mask_r[ch_sel_s]) begin
            addend_s = {{(ACC_W-IN_W){snap_r[ch_sel_s][IN_W-1]}}, snap_r[ch_sel_s]};
        end else begin
            addend_s = {ACC_W{1'b0}};
        end
    end

    beam_shift_sat #(
        .ACC_W (ACC_W),
        .OUT_W (IN_W),
        .SHIFT (SHIFT)
    ) u_shift_sat (
        .acc (acc_r),
        .sat (sat_s)
    );

    // FSM, frame snapshot, serial accumulation and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            mask_r         <= {NUM_CH{1'b0}};
            acc_r          <= {ACC_W{1'b0}};
            idx_r          <= {CNT_W{1'b0}};
            in_ready_r     <= 1'b0;
            out_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
            out_data_r     <= {IN_W{1'b0}};
            active_count_r <= {CNT_W{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                snap_r[k] <= {IN_W{1'b0}};
            end
        end else begin
            // A refused offer wins over a clear in the same cycle
            if (bus.in_valid && !in_ready_r) begin
                overrun_r <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap_r[k] <= bus.pcm_in[k*IN_W +: IN_W];
                        end
                        mask_r         <= bus.ch_enable;
                        acc_r          <= {ACC_W{1'b0}};
                        idx_r          <= {CNT_W{1'b0}};
                        active_count_r <= popcount(bus.ch_enable);
                        in_ready_r     <= 1'b0;
                        busy_r         <= 1'b1;
                        state_r        <= ACCUM;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ACCUM: begin
                    // idx reaching NUM_CH means every channel has been added into acc_r
                    if (idx_r == CNT_W'(NUM_CH)) begin
                        out_data_r  <= sat_s;
                        out_valid_r <= 1'b1;
                        state_r     <= OUT;
                    end else begin
                        acc_r <= acc_r + addend_s;
                        idx_r <= idx_r + CNT_W'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.active_count = active_count_r;
    assign bus.busy         = busy_r;
    assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_beam_sum_accumulator.sv
// Directed and randomized checks of beam_sum_accumulator (SHIFT=4 and SHIFT=0 instances) against a reference model.
module tb_beam_sum_accumulator;
    import beam_pkg::*;

    localparam int NUM_CH = NUM_MICS;
    localparam int IN_W   = PCM_W;
    localparam int CNT_W  = $clog2(NUM_CH + 1);
    localparam int PW     = NUM_CH * IN_W;
    localparam int LAT    = NUM_CH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    beam_sum_accumulator_if #(.NUM_CH(NUM_CH), .IN_W(IN_W)) bus_a ();
    beam_sum_accumulator_if #(.NUM_CH(NUM_CH), .IN_W(IN_W)) bus_b ();

    beam_sum_accumulator #(.NUM_CH(NUM_CH), .IN_W(IN_W), .SHIFT(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    beam_sum_accumulator #(.NUM_CH(NUM_CH), .IN_W(IN_W), .SHIFT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Reference: exact sum, floor division by 2^sh, clamp to the output range
    function automatic logic signed [31:0] ref_out(input logic [PW-1:0] pcm, input logic [NUM_CH-1:0] m, input int sh);
        longint sum, d, q, lim;
        logic signed [IN_W-1:0] s;
        sum = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            s = pcm[k*IN_W +: IN_W];
            if (m[k]) sum += longint'(s);
        end
        d = longint'(1) << sh;
        q = (sum >= 0) ? sum / d : -((-sum + d - 1) / d);
        lim = longint'(1) << (IN_W - 1);
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return 32'(q);
    endfunction

    function automatic logic [PW-1:0] fill(input int val);
        logic [PW-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k*IN_W +: IN_W] = IN_W'(val);
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_pcm();
        logic [PW-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k*IN_W +: IN_W] = IN_W'($urandom);
        return v;
    endfunction

    function automatic logic rd_valid(input int sel);
        return (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
    endfunction
    function automatic logic rd_ready(input int sel);
        return (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction
    function automatic logic rd_busy(input int sel);
        return (sel == 0) ? bus_a.busy : bus_b.busy;
    endfunction
    function automatic logic rd_ovr(input int sel);
        return (sel == 0) ? bus_a.overrun : bus_b.overrun;
    endfunction
    function automatic logic signed [31:0] rd_data(input int sel);
        return (sel == 0) ? bus_a.out_data : bus_b.out_data;
    endfunction
    function automatic logic [CNT_W-1:0] rd_cnt(input int sel);
        return (sel == 0) ? bus_a.active_count : bus_b.active_count;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [PW-1:0] pcm, input logic [NUM_CH-1:0] m);
        if (sel == 0) begin
            bus_a.in_valid = v; bus_a.pcm_in = pcm; bus_a.ch_enable = m;
        end else begin
            bus_b.in_valid = v; bus_b.pcm_in = pcm; bus_b.ch_enable = m;
        end
    endtask

    task automatic set_out_ready(input int sel, input logic v);
        if (sel == 0) bus_a.out_ready = v;
        else bus_b.out_ready = v;
    endtask

    // Offers one frame when in_ready is seen, then scrambles the inputs right after the accept edge
    task automatic send_frame(input int sel, input logic [PW-1:0] pcm, input logic [NUM_CH-1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while (!rd_ready(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 32'(rd_ready(sel)), 32'sd1);
        set_in(sel, 1'b1, pcm, m);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, ~pcm, ~m);
        check("busy_after_accept", 32'(rd_busy(sel)), 32'sd1);
        check("in_ready_after_accept", 32'(rd_ready(sel)), 32'sd0);
    endtask

    // Counts accept-to-out_valid edges (bounded) and checks the result
    task automatic wait_out(input int sel, input string tag, input logic signed [31:0] exp, input int cnt);
        int n;
        n = 0;
        while (!rd_valid(sel) && n < 4 * LAT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_data"}, rd_data(sel), exp);
        check({tag, "_active_count"}, 32'(rd_cnt(sel)), cnt);
    endtask

    task automatic handshake(input int sel);
        set_out_ready(sel, 1'b1);
        @(posedge clk);
        #1;
        set_out_ready(sel, 1'b0);
        check("out_valid_after_hs", 32'(rd_valid(sel)), 32'sd0);
        check("in_ready_after_hs", 32'(rd_ready(sel)), 32'sd1);
    endtask

    initial begin
        logic [PW-1:0]        pcm;
        logic [NUM_CH-1:0]    m;
        logic signed [31:0]   expd;
        logic signed [31:0]   held;
        logic signed [31:0]   exq[$];
        int                   cnq[$];
        int                   last, nout, seen;

        set_in(0, 1'b0, '0, '0); set_in(1, 1'b0, '0, '0);
        bus_a.out_ready = 1'b0; bus_a.overrun_clr = 1'b0;
        bus_b.out_ready = 1'b0; bus_b.overrun_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus_a.in_ready), 32'sd0);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'sd0);
        check("rst_busy", 32'(bus_a.busy), 32'sd0);
        check("rst_overrun", 32'(bus_a.overrun), 32'sd0);
        check("rst_out_data", rd_data(0), 32'sd0);
        check("rst_active_count", 32'(bus_a.active_count), 32'sd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_first_edge", 32'(bus_a.in_ready), 32'sd1);

        // 1: all channels +1000
        send_frame(0, fill(1000), 16'hFFFF);
        wait_out(0, "all_1000", 32'sd1000, 16);
        handshake(0);

        // 2: single negative channel floors; alternating signs cancel
        pcm = fill(0);
        pcm[IN_W-1:0] = IN_W'(-17);
        send_frame(0, pcm, 16'h0001);
        wait_out(0, "neg17", 32'(-2), 1);
        handshake(0);
        for (int k = 0; k < NUM_CH; k++) pcm[k*IN_W +: IN_W] = (k % 2 == 0) ? IN_W'(1000) : IN_W'(-1000);
        send_frame(0, pcm, 16'hFFFF);
        wait_out(0, "alternating", 32'sd0, 16);
        handshake(0);

        // Random frames, SHIFT=4
        for (int i = 0; i < 6; i++) begin
            pcm = rand_pcm();
            m = NUM_CH'($urandom);
            send_frame(0, pcm, m);
            wait_out(0, "rand_shift4", ref_out(pcm, m, 4), $countones(m));
            handshake(0);
        end

        // 3: SHIFT=0 instance saturates at both rails
        send_frame(1, fill(262143), 16'hFFFF);
        wait_out(1, "sat_pos", 32'sd262143, 16);
        handshake(1);
        send_frame(1, fill(-262144), 16'hFFFF);
        wait_out(1, "sat_neg", -32'sd262144, 16);
        handshake(1);
        for (int i = 0; i < 4; i++) begin
            pcm = rand_pcm();
            m = NUM_CH'($urandom);
            send_frame(1, pcm, m);
            wait_out(1, "rand_shift0", ref_out(pcm, m, 0), $countones(m));
            handshake(1);
        end

        // 4: output held under backpressure, overrun set/clear priority, offered frame dropped
        pcm = rand_pcm();
        send_frame(0, pcm, 16'hFFFF);
        expd = ref_out(pcm, 16'hFFFF, 4);
        wait_out(0, "hold", expd, 16);
        held = rd_data(0);
        repeat (3) begin
            @(negedge clk);
            check("hold_data", rd_data(0), expd);
            check("hold_in_ready", 32'(bus_a.in_ready), 32'sd0);
        end
        set_in(0, 1'b1, rand_pcm(), 16'hFFFF);
        @(negedge clk);
        set_in(0, 1'b0, '0, '0);
        check("overrun_set", 32'(bus_a.overrun), 32'sd1);
        set_in(0, 1'b1, rand_pcm(), 16'hFFFF);
        bus_a.overrun_clr = 1'b1;
        @(negedge clk);
        set_in(0, 1'b0, '0, '0);
        bus_a.overrun_clr = 1'b0;
        check("overrun_set_wins", 32'(bus_a.overrun), 32'sd1);
        @(negedge clk);
        bus_a.overrun_clr = 1'b1;
        @(negedge clk);
        bus_a.overrun_clr = 1'b0;
        check("overrun_cleared", 32'(bus_a.overrun), 32'sd0);
        repeat (3) @(negedge clk);
        check("hold_data_end", rd_data(0), held);
        check("hold_valid_end", 32'(bus_a.out_valid), 32'sd1);
        handshake(0);
        seen = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (bus_a.out_valid) seen++;
        end
        check("dropped_frame_no_output", seen, 0);

        // 5: reset in the middle of accumulation
        send_frame(0, rand_pcm(), 16'hFFFF);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus_a.out_valid), 32'sd0);
        check("midrst_busy", 32'(bus_a.busy), 32'sd0);
        check("midrst_in_ready", 32'(bus_a.in_ready), 32'sd0);
        check("midrst_out_data", rd_data(0), 32'sd0);
        check("midrst_active_count", 32'(bus_a.active_count), 32'sd0);
        seen = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (bus_a.out_valid) seen++;
        end
        check("midrst_no_output", seen, 0);
        rst = 1'b0;
        send_frame(0, fill(5), 16'hFFFF);
        wait_out(0, "after_rst", 32'sd5, 16);
        handshake(0);

        // 6: empty mask, then back-to-back frames with out_ready tied high
        send_frame(0, rand_pcm() | fill(1), 16'h0000);
        wait_out(0, "mask_zero", 32'sd0, 0);
        handshake(0);
        set_out_ready(0, 1'b1);
        last = -1;
        nout = 0;
        for (int cyc = 0; cyc < 8 * (LAT + 2) && nout < 6; cyc++) begin
            @(negedge clk);
            if (bus_a.out_valid) begin
                if (exq.size() > 0) begin
                    check("b2b_data", rd_data(0), exq.pop_front());
                    check("b2b_active_count", 32'(bus_a.active_count), cnq.pop_front());
                end else begin
                    check("b2b_unexpected_output", 32'sd1, 32'sd0);
                end
                if (last >= 0) check("b2b_period", cyc - last, LAT + 2);
                last = cyc;
                nout++;
            end
            if (bus_a.in_ready) begin
                pcm = rand_pcm();
                m = NUM_CH'($urandom);
                exq.push_back(ref_out(pcm, m, 4));
                cnq.push_back($countones(m));
                set_in(0, 1'b1, pcm, m);
            end else begin
                set_in(0, 1'b0, '0, '0);
            end
        end
        set_in(0, 1'b0, '0, '0);
        set_out_ready(0, 1'b0);
        check("b2b_outputs", nout, 6);
        check("b2b_no_overrun", 32'(bus_a.overrun), 32'sd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
